time_set_ctrl: RTL and testbench

//  Time-setting sequencer for the digital clock. Decodes debounced key pulses into a
//  RUN/SET_H/SET_M/SET_S/COMMIT state machine and edits a BCD copy of the live time.

---
 rtl/time_set_pkg.sv | 38 +++
 rtl/bcd_field_step.sv | 37 +++
 rtl/time_set_ctrl.sv | 146 ++++++++++++++
 tb/tb_time_set_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-setting sequencer.
package time_set_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_H  = 3'd1,
    ST_SET_M  = 3'd2,
    ST_SET_S  = 3'd3,
    ST_COMMIT = 3'd4
  } tsc_state_t;

  // Field index = byte position inside the 24-bit BCD time word
  localparam int FIELD_S = 0;
  localparam int FIELD_M = 1;
  localparam int FIELD_H = 2;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  localparam int KEY_MODE = 0;
  localparam int KEY_UP   = 1;
  localparam int KEY_DOWN = 2;

  // Map an editing state to the field it edits (seconds for anything else)
  function automatic logic [1:0] state_field(input tsc_state_t st);
    case (st)
      ST_SET_H: return 2'(FIELD_H);
      ST_SET_M: return 2'(FIELD_M);
      default:  return 2'(FIELD_S);
    endcase
  endfunction

  // Two-digit blank pattern for a field; bit5 is the hour tens digit
  function automatic logic [5:0] field_blank(input logic [1:0] fld);
    return 6'b000011 << {fld, 1'b0};
  endfunction

endpackage

// File: rtl/bcd_field_step.sv
// Combinational two-digit BCD increment/decrement with wrap at max_value.
// An invalid input (nibble above 9 or value above max) snaps to 00 on any step.
module bcd_field_step (
  input  logic [7:0] value,
  input  logic [7:0] max_value,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] result
);

  logic [3:0] tens;
  logic [3:0] units;
  logic       valid;

  assign tens  = value[7:4];
  assign units = value[3:0];
  assign valid = (tens <= 4'd9) && (units <= 4'd9) && (value <= max_value);

  // Step the field; inc and dec together cancel out
  always_comb begin
    result = value;
    if (inc ^ dec) begin
      if (!valid) begin
        result = 8'h00;
      end else if (inc) begin
        if (value == max_value)   result = 8'h00;
        else if (units == 4'd9)   result = {tens + 4'd1, 4'd0};
        else                      result = {tens, units + 4'd1};
      end else begin
        if (value == 8'h00)       result = max_value;
        else if (units == 4'd0)   result = {tens - 4'd1, 4'd9};
        else                      result = {tens, units - 4'd1};
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting sequencer: RUN -> SET_H -> SET_M -> SET_S -> COMMIT -> RUN.
// Edits a BCD copy of the live time, halts the counter while editing,
// pulses load on commit and blinks the field being edited.
// Optional build macro TSC_AUTO_EXIT_EN: abandon the edit after IDLE_TIMEOUT
// idle cycles in any SET state.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int BLINK_HALF   = 25_000_000,
  parameter int IDLE_TIMEOUT = 500_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  key_vld,
  input  logic [23:0] cur_time,
  output logic        set_mode,
  output logic        cnt_en,
  output logic        load,
  output logic [23:0] load_time,
  output logic [5:0]  blank_mask
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  tsc_state_t    state_q, state_d;
  logic [23:0]   edit_q, edit_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  logic          key_mode, key_up, key_down, key_any;
  logic          in_set, in_set_d;
  logic [1:0]    field_idx;
  logic [4:0]    field_base;
  logic [7:0]    field_val, field_max, field_next;

  assign key_mode = key_vld[KEY_MODE];
  assign key_up   = key_vld[KEY_UP];
  assign key_down = key_vld[KEY_DOWN];
  assign key_any  = |key_vld;

  assign in_set     = state_q inside {ST_SET_H, ST_SET_M, ST_SET_S};
  assign in_set_d   = state_d inside {ST_SET_H, ST_SET_M, ST_SET_S};
  assign field_idx  = state_field(state_q);
  assign field_base = {field_idx, 3'b000};
  assign field_val  = edit_q[field_base +: 8];
  assign field_max  = (state_q == ST_SET_H) ? HOUR_MAX : MINSEC_MAX;

  // MODE has priority, so a step only happens when MODE is absent
  bcd_field_step u_step (
    .value     (field_val),
    .max_value (field_max),
    .inc       (in_set & key_up & ~key_mode),
    .dec       (in_set & key_down & ~key_mode),
    .result    (field_next)
  );

`ifdef TSC_AUTO_EXIT_EN
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  logic [IW-1:0] idle_q, idle_d;
  logic          idle_expire;

  assign idle_expire = in_set && !key_any && (idle_q == IDLE_LAST);

  // Idle counter restarts on any key, on state change and outside SET states
  always_comb begin
    idle_d = idle_q + IW'(1);
    if (!in_set || key_any || (state_d != state_q)) idle_d = '0;
  end

  // Idle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  logic unused_idle_timeout;
  assign unused_idle_timeout = (IDLE_TIMEOUT == 0);
`endif

  // Next state, edit register, blink timer and next output values
  always_comb begin
    state_d     = state_q;
    edit_d      = edit_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;

    case (state_q)
      ST_RUN: begin
        if (key_mode) begin
          state_d = ST_SET_H;
          edit_d  = cur_time;
        end
      end
      ST_SET_H:  if (key_mode) state_d = ST_SET_M;
      ST_SET_M:  if (key_mode) state_d = ST_SET_S;
      ST_SET_S:  if (key_mode) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase

    if (in_set && !key_mode) edit_d[field_base +: 8] = field_next;

`ifdef TSC_AUTO_EXIT_EN
    if (idle_expire) state_d = ST_RUN;
`endif

    if (!in_set_d || (state_d != state_q) || key_up || key_down) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end
  end

  // State and registered outputs, all derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      edit_q      <= 24'h0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      set_mode    <= 1'b0;
      cnt_en      <= 1'b1;
      load        <= 1'b0;
      blank_mask  <= 6'b0;
    end else begin
      state_q     <= state_d;
      edit_q      <= edit_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      set_mode    <= (state_d != ST_RUN);
      cnt_en      <= (state_d == ST_RUN);
      load        <= (state_d == ST_COMMIT);
      blank_mask  <= (phase_d && in_set_d) ? field_blank(state_field(state_d)) : 6'b0;
    end
  end

  assign load_time = edit_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed, table-driven bench for time_set_ctrl (BLINK_HALF=4, IDLE_TIMEOUT=16).
module tb_time_set_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  key_vld = 3'b000;
  logic [23:0] cur_time = 24'h0;
  logic        set_mode, cnt_en, load;
  logic [23:0] load_time;
  logic [5:0]  blank_mask;

  int n_compared = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [2:0]  key;
    logic [23:0] cur;
    logic        sm;
    logic        ce;
    logic        ld;
    logic [23:0] lt;
    logic [5:0]  bm;
  } vec_t;

  vec_t vecs[$];

  time_set_ctrl #(.BLINK_HALF(4), .IDLE_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_vld    (key_vld),
    .cur_time   (cur_time),
    .set_mode   (set_mode),
    .cnt_en     (cnt_en),
    .load       (load),
    .load_time  (load_time),
    .blank_mask (blank_mask)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, sample 1 time unit after the rising edge
  task automatic applyStimulus(input logic [2:0] k, input logic [23:0] t);
    @(negedge clk);
    key_vld  = k;
    cur_time = t;
    @(posedge clk);
    #1;
    key_vld = 3'b000;
  endtask

  task automatic checkOutput(input string name, input logic sm, input logic ce, input logic ld,
                             input logic [23:0] lt, input logic [5:0] bm);
    n_compared++;
    if ({set_mode, cnt_en, load, load_time, blank_mask} !== {sm, ce, ld, lt, bm}) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got sm=%b ce=%b ld=%b lt=%h bm=%b, expected sm=%b ce=%b ld=%b lt=%h bm=%b",
               name, set_mode, cnt_en, load, load_time, blank_mask, sm, ce, ld, lt, bm);
    end
  endtask

  task automatic addVec(input logic [2:0] k, input logic [23:0] t, input logic sm, input logic ce,
                        input logic ld, input logic [23:0] lt, input logic [5:0] bm);
    vec_t v;
    v.key = k; v.cur = t; v.sm = sm; v.ce = ce; v.ld = ld; v.lt = lt; v.bm = bm;
    vecs.push_back(v);
  endtask

  initial begin
    // capture, blink in SET_H, one UP, commit, UP ignored in RUN
    addVec(3'b001, 24'h123456, 1, 0, 0, 24'h123456, 6'b000000);
    addVec(3'b000, 24'h000000, 1, 0, 0, 24'h123456, 6'b000000);
    addVec(3'b000, 24'h000000, 1, 0, 0, 24'h123456, 6'b000000);
    addVec(3'b000, 24'h000000, 1, 0, 0, 24'h123456, 6'b000000);
    addVec(3'b000, 24'h000000, 1, 0, 0, 24'h123456, 6'b110000);
    addVec(3'b010, 24'h000000, 1, 0, 0, 24'h133456, 6'b000000);
    addVec(3'b001, 24'h000000, 1, 0, 0, 24'h133456, 6'b000000);
    addVec(3'b001, 24'h000000, 1, 0, 0, 24'h133456, 6'b000000);
    addVec(3'b001, 24'h000000, 1, 0, 1, 24'h133456, 6'b000000);
    addVec(3'b000, 24'h000000, 0, 1, 0, 24'h133456, 6'b000000);
    addVec(3'b010, 24'h000000, 0, 1, 0, 24'h133456, 6'b000000);
    // wrap boundaries on every field
    addVec(3'b001, 24'h235959, 1, 0, 0, 24'h235959, 6'b000000);
    addVec(3'b010, 24'h000000, 1, 0, 0, 24'h005959, 6'b000000);
    addVec(3'b100, 24'h000000, 1, 0, 0, 24'h235959, 6'b000000);
    addVec(3'b001, 24'h000000, 1, 0, 0, 24'h235959, 6'b000000);
    addVec(3'b010, 24'h000000, 1, 0, 0, 24'h230059, 6'b000000);
    addVec(3'b100, 24'h000000, 1, 0, 0, 24'h235959, 6'b000000);
    addVec(3'b001, 24'h000000, 1, 0, 0, 24'h235959, 6'b000000);
    addVec(3'b010, 24'h000000, 1, 0, 0, 24'h235900, 6'b000000);
    addVec(3'b100, 24'h000000, 1, 0, 0, 24'h235959, 6'b000000);
    addVec(3'b001, 24'h000000, 1, 0, 1, 24'h235959, 6'b000000);
    addVec(3'b000, 24'h000000, 0, 1, 0, 24'h235959, 6'b000000);
    // full edit path from 10:20:30 to 12:19:30
    addVec(3'b001, 24'h102030, 1, 0, 0, 24'h102030, 6'b000000);
    addVec(3'b010, 24'h000000, 1, 0, 0, 24'h112030, 6'b000000);
    addVec(3'b010, 24'h000000, 1, 0, 0, 24'h122030, 6'b000000);
    addVec(3'b001, 24'h000000, 1, 0, 0, 24'h122030, 6'b000000);
    addVec(3'b100, 24'h000000, 1, 0, 0, 24'h121930, 6'b000000);
    addVec(3'b001, 24'h000000, 1, 0, 0, 24'h121930, 6'b000000);
    addVec(3'b001, 24'h000000, 1, 0, 1, 24'h121930, 6'b000000);
    addVec(3'b000, 24'h000000, 0, 1, 0, 24'h121930, 6'b000000);
    // invalid captured fields and simultaneous keys
    addVec(3'b001, 24'h2A5999, 1, 0, 0, 24'h2A5999, 6'b000000);
    addVec(3'b010, 24'h000000, 1, 0, 0, 24'h005999, 6'b000000);
    addVec(3'b001, 24'h000000, 1, 0, 0, 24'h005999, 6'b000000);
    addVec(3'b011, 24'h000000, 1, 0, 0, 24'h005999, 6'b000000);
    addVec(3'b110, 24'h000000, 1, 0, 0, 24'h005999, 6'b000000);
    addVec(3'b100, 24'h000000, 1, 0, 0, 24'h005900, 6'b000000);
    addVec(3'b001, 24'h000000, 1, 0, 1, 24'h005900, 6'b000000);
    addVec(3'b000, 24'h000000, 0, 1, 0, 24'h005900, 6'b000000);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 0, 1, 0, 24'h0, 6'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].key, vecs[i].cur);
      checkOutput($sformatf("vec%0d", i), vecs[i].sm, vecs[i].ce, vecs[i].ld, vecs[i].lt, vecs[i].bm);
    end

    // blink in SET_M: 4 visible, 4 blanked, then UP makes it visible again
    applyStimulus(3'b001, 24'h084512);
    applyStimulus(3'b001, 24'h000000);
    checkOutput("blink_m0", 1, 0, 0, 24'h084512, 6'b000000);
    for (int k = 1; k < 12; k++) begin
      applyStimulus(3'b000, 24'h000000);
      checkOutput($sformatf("blink_m%0d", k), 1, 0, 0, 24'h084512,
                  (((k / 4) % 2) == 1) ? 6'b001100 : 6'b000000);
    end
    applyStimulus(3'b010, 24'h000000);
    checkOutput("blink_up", 1, 0, 0, 24'h084612, 6'b000000);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(3'b000, 24'h000000);
      checkOutput($sformatf("blink_after_up%0d", k), 1, 0, 0, 24'h084612,
                  (k == 4) ? 6'b001100 : 6'b000000);
    end

    // reset in SET_S drops the edit with no load pulse
    applyStimulus(3'b001, 24'h000000);
    checkOutput("pre_rst_set_s", 1, 0, 0, 24'h084612, 6'b000000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async", 0, 1, 0, 24'h0, 6'b0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("rst_hold%0d", k), 0, 1, 0, 24'h0, 6'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(3'b000, 24'h000000);
      checkOutput($sformatf("post_rst%0d", k), 0, 1, 0, 24'h0, 6'b0);
    end

`ifdef TSC_AUTO_EXIT_EN
    // 16 idle cycles in SET_H abandon the edit
    applyStimulus(3'b001, 24'h111111);
    checkOutput("auto_enter", 1, 0, 0, 24'h111111, 6'b000000);
    for (int k = 1; k < 16; k++) begin
      applyStimulus(3'b000, 24'h000000);
      checkOutput($sformatf("auto_idle%0d", k), 1, 0, 0, 24'h111111,
                  (((k / 4) % 2) == 1) ? 6'b110000 : 6'b000000);
    end
    applyStimulus(3'b000, 24'h000000);
    checkOutput("auto_exit", 0, 1, 0, 24'h111111, 6'b000000);
    applyStimulus(3'b000, 24'h000000);
    checkOutput("auto_after", 0, 1, 0, 24'h111111, 6'b000000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    n_mismatched++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
